// File: rtl/mac_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mac_pipe_pkg
//   Shared definitions for the mac_pipe multiply-accumulate pipeline:
//     - DEFAULT_WIDTH / DEFAULT_ACC_W : default operand and accumulator widths
//     - mode_e                        : operation select (load or accumulate)
//     - stage_ctrl_t                  : control word carried down each stage
//     - STAGE_IDLE                    : reset / bubble value of stage_ctrl_t
// -----------------------------------------------------------------------------
package mac_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_ACC_W = 2 * DEFAULT_WIDTH + 4;

  // MODE_LOAD : result = a*b + c
  // MODE_ACC  : result = previous valid result + a*b
  typedef enum logic {
    MODE_LOAD = 1'b0,
    MODE_ACC  = 1'b1
  } mode_e;

  // Control word that travels alongside the data in every stage.
  // valid=0 marks a bubble; mode is don't-care for a bubble.
  typedef struct packed {
    logic  valid;
    mode_e mode;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_IDLE = '{valid: 1'b0, mode: MODE_LOAD};

endpackage

// File: rtl/mac_sat_add.sv
// -----------------------------------------------------------------------------
// mac_sat_add
//   Combinational ACC_W-bit unsigned adder for the final pipeline stage.
//   The sum is formed at ACC_W+1 bits; the carry-out is the overflow flag.
//
//   Configuration macro: MAC_PIPE_SAT_EN
//     defined   : on overflow the result saturates to all ones
//     undefined : the result wraps modulo 2^ACC_W (overflow still reported)
//
// Ports
//   base_i   in  ACC_W  first operand (addend c or running accumulator)
//   addend_i in  ACC_W  second operand (zero-extended product)
//   sum_o    out ACC_W  result (wrapped or saturated)
//   ovf_o    out 1      exact sum exceeded 2^ACC_W-1
// -----------------------------------------------------------------------------
module mac_sat_add #(
  parameter int ACC_W = 20
) (
  input  logic [ACC_W-1:0] base_i,
  input  logic [ACC_W-1:0] addend_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W:0] sum_full;

  always_comb begin
    sum_full = {1'b0, base_i} + {1'b0, addend_i};
    ovf_o    = sum_full[ACC_W];
`ifdef MAC_PIPE_SAT_EN
    sum_o    = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    sum_o    = sum_full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/mac_pipe.sv
// -----------------------------------------------------------------------------
// mac_pipe
//   Three-stage unsigned multiply-accumulate pipeline with valid/ready
//   handshakes on both sides.
//
//     S1 : registers a, b, c, mode and valid of an accepted beat
//     S2 : registers the 2*WIDTH product, delays c and mode
//     S3 : registers the sum, ovf and valid (output register)
//
//   Latency is 3 cycles from acceptance to out_valid_o with no stall.
//   The accumulator is the S3 result register itself: it only updates on a
//   valid beat, so it always holds the last valid result, and a MODE_ACC beat
//   in S2 reads the value produced on the immediately preceding cycle with no
//   extra forwarding path.
//
//   Handshake semantics (both ports):
//     A beat transfers on a rising edge where valid and ready are both 1.
//     Downstream: stall = out_valid_o & ~out_ready_i. While stalled, every
//     stage holds and in_ready_o is 0. in_ready_o = ~stall (and 0 during
//     reset), giving one beat per cycle when out_ready_i stays high.
//
//   Configuration macro: MAC_PIPE_SAT_EN (saturate on overflow; see
//   mac_sat_add). Undefined by default: results wrap, ovf still reported.
//
// Ports
//   clk          in  1      clock, rising edge
//   rst_n        in  1      asynchronous active-low reset
//   a_i, b_i     in  WIDTH  unsigned multiplicand / multiplier
//   c_i          in  ACC_W  addend, used only for MODE_LOAD
//   mode_i       in  1      0 = a*b+c, 1 = accumulator + a*b
//   in_valid_i   in  1      input beat valid
//   in_ready_o   out 1      pipeline can accept a beat
//   out_valid_o  out 1      data_out_o / ovf_o hold a result
//   out_ready_i  in  1      downstream accepts the result
//   data_out_o   out ACC_W  result
//   ovf_o        out 1      the result on data_out_o overflowed
// -----------------------------------------------------------------------------
module mac_pipe
  import mac_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ACC_W = DEFAULT_ACC_W   // must be >= 2*WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [ACC_W-1:0] c_i,
  input  logic             mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] data_out_o,
  output logic             ovf_o
);

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  stage_ctrl_t            s1_ctrl_q, s1_ctrl_d;
  logic [WIDTH-1:0]       s1_a_q, s1_a_d;
  logic [WIDTH-1:0]       s1_b_q, s1_b_d;
  logic [ACC_W-1:0]       s1_c_q, s1_c_d;

  stage_ctrl_t            s2_ctrl_q, s2_ctrl_d;
  logic [2*WIDTH-1:0]     s2_prod_q, s2_prod_d;
  logic [ACC_W-1:0]       s2_c_q, s2_c_d;

  logic                   out_valid_q, out_valid_d;
  logic [ACC_W-1:0]       data_q, data_d;      // also the accumulator
  logic                   ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic stall;
  logic advance;
  logic accept;

  assign stall      = out_valid_q & ~out_ready_i;
  assign advance    = ~stall;
  // Gated by rst_n so nothing is offered as accepted while reset is held.
  assign in_ready_o = rst_n & ~stall;
  assign accept     = in_valid_i & in_ready_o;

  // ---------------------------------------------------------------------------
  // S3 adder: MODE_ACC adds onto the current result register, which already
  // contains the previous cycle's result when beats are back-to-back.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] add_base;
  logic [ACC_W-1:0] add_addend;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  assign add_base   = (s2_ctrl_q.mode == MODE_ACC) ? data_q : s2_c_q;
  assign add_addend = ACC_W'(s2_prod_q);

  mac_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .base_i   (add_base),
    .addend_i (add_addend),
    .sum_o    (add_sum),
    .ovf_o    (add_ovf)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_ctrl_d   = s1_ctrl_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_c_d      = s1_c_q;
    s2_ctrl_d   = s2_ctrl_q;
    s2_prod_d   = s2_prod_q;
    s2_c_d      = s2_c_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    ovf_d       = ovf_q;

    if (advance) begin
      // S1: capture operands only for a real beat; a bubble just clears valid.
      s1_ctrl_d.valid = accept;
      s1_ctrl_d.mode  = mode_e'(mode_i);
      if (accept) begin
        s1_a_d = a_i;
        s1_b_d = b_i;
        s1_c_d = c_i;
      end

      // S2: operands widened first so the product is computed at 2*WIDTH.
      s2_ctrl_d = s1_ctrl_q;
      s2_prod_d = {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};
      s2_c_d    = s1_c_q;

      // S3: result and ovf only change on a valid beat, so bubbles leave the
      // accumulator and the visible output untouched.
      out_valid_d = s2_ctrl_q.valid;
      if (s2_ctrl_q.valid) begin
        data_d = add_sum;
        ovf_d  = add_ovf;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ctrl_q   <= STAGE_IDLE;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      s2_ctrl_q   <= STAGE_IDLE;
      s2_prod_q   <= '0;
      s2_c_q      <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_ctrl_q   <= s1_ctrl_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_c_q      <= s1_c_d;
      s2_ctrl_q   <= s2_ctrl_d;
      s2_prod_q   <= s2_prod_d;
      s2_c_q      <= s2_c_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign data_out_o  = data_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_mac_pipe
//   Directed testbench for mac_pipe (WIDTH=8, ACC_W=20). Expected results are
//   hand-computed constants, plus a small arithmetic model for the long
//   overflow run. Build with +define+MAC_PIPE_SAT_EN to check saturation.
// -----------------------------------------------------------------------------
module tb_mac_pipe;

  localparam int WIDTH     = 8;
  localparam int ACC_W     = 20;
  localparam int CYC_LIMIT = 40;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [ACC_W-1:0] c = '0;
  logic             mode = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] data_out;
  logic             ovf;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mac_pipe #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_i         (a),
    .b_i         (b),
    .c_i         (c),
    .mode_i      (mode),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_out_o  (data_out),
    .ovf_o       (ovf)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int total  = 0;
  int passed = 0;

  logic [ACC_W:0]   exp_q[$];     // {ovf, data}
  int               out_cyc[$];
  int               out_count = 0;
  logic [ACC_W-1:0] last_data = '0;
  logic             last_ovf  = 1'b0;
  logic [ACC_W:0]   mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Outputs are sampled on the falling edge; a beat with valid & ready here
  // transfers on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_count++;
      out_cyc.push_back(int'(cyc));
      last_data = data_out;
      last_ovf  = ovf;
      if (exp_q.size() == 0) begin
        fail_now($sformatf("unexpected_output data=%0d ovf=%0d", data_out, ovf));
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", 64'(data_out), 64'(mon_e[ACC_W-1:0]));
        check("ovf", 64'(ovf), 64'(mon_e[ACC_W]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                      input logic [ACC_W-1:0] c_v, input logic m_v);
    bit done;
    done     = 1'b0;
    a        = a_v;
    b        = b_v;
    c        = c_v;
    mode     = m_v;
    in_valid = 1'b1;
    for (int i = 0; i < CYC_LIMIT && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      tick();
    end
    if (!done) fail_now("send_timeout");
    in_valid = 1'b0;
  endtask

  task automatic expect_beat(input logic [ACC_W-1:0] d, input logic o);
    exp_q.push_back({o, d});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < CYC_LIMIT && exp_q.size() != 0; i++) tick();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Reference arithmetic for the long overflow run.
  logic [ACC_W-1:0] m_acc = '0;
  task automatic model_beat(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                            input logic [ACC_W-1:0] c_v, input logic m_v);
    logic [ACC_W:0] full;
    logic [ACC_W:0] prod;
    prod = (ACC_W+1)'(a_v) * (ACC_W+1)'(b_v);
    full = (m_v ? {1'b0, m_acc} : {1'b0, c_v}) + prod;
`ifdef MAC_PIPE_SAT_EN
    m_acc = full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    m_acc = full[ACC_W-1:0];
`endif
    expect_beat(m_acc, full[ACC_W]);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [ACC_W-1:0] c;
    logic             mode;
    logic [ACC_W-1:0] exp_data;
    logic             exp_ovf;
  } vec_t;

  localparam int NVEC = 9;
  vec_t tbl[NVEC];

  localparam int NBP = 6;
  vec_t bp[NBP];

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [ACC_W-1:0] held;
    int               cnt0;

    tbl[0] = '{8'd2,   8'd3,   20'd1,       1'b0, 20'd7,   1'b0};
    tbl[1] = '{8'd4,   8'd5,   20'd0,       1'b1, 20'd27,  1'b0};
    tbl[2] = '{8'd1,   8'd1,   20'd0,       1'b1, 20'd28,  1'b0};
    tbl[3] = '{8'd10,  8'd20,  20'd7,       1'b0, 20'd207, 1'b0};
    tbl[4] = '{8'd0,   8'd0,   20'd0,       1'b1, 20'd207, 1'b0};
    tbl[5] = '{8'd15,  8'd15,  20'd0,       1'b1, 20'd432, 1'b0};
`ifdef MAC_PIPE_SAT_EN
    tbl[6] = '{8'd255, 8'd255, 20'd1048575, 1'b0, 20'd1048575, 1'b1};
    tbl[7] = '{8'd1,   8'd1,   20'd0,       1'b1, 20'd1048575, 1'b1};
`else
    tbl[6] = '{8'd255, 8'd255, 20'd1048575, 1'b0, 20'd65024, 1'b1};
    tbl[7] = '{8'd1,   8'd1,   20'd0,       1'b1, 20'd65025, 1'b0};
`endif
    tbl[8] = '{8'd0,   8'd0,   20'd5,       1'b0, 20'd5,   1'b0};

    bp[0] = '{8'd1,  8'd2,  20'd3,   1'b0, 20'd5,   1'b0};
    bp[1] = '{8'd2,  8'd2,  20'd0,   1'b1, 20'd9,   1'b0};
    bp[2] = '{8'd3,  8'd3,  20'd0,   1'b1, 20'd18,  1'b0};
    bp[3] = '{8'd1,  8'd5,  20'd100, 1'b0, 20'd105, 1'b0};
    bp[4] = '{8'd2,  8'd5,  20'd0,   1'b1, 20'd115, 1'b0};
    bp[5] = '{8'd10, 8'd10, 20'd0,   1'b1, 20'd215, 1'b0};

    // ---- reset ----
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data_out",  64'(data_out),  64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // ---- single beat, latency 3 ----
    a = 8'd3; b = 8'd4; c = 20'd5; mode = 1'b0; in_valid = 1'b1;
    expect_beat(20'd17, 1'b0);
    @(negedge clk);
    check("single_accept", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_no_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2_no_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle3_valid", 64'(out_valid), 64'd1);
    check("single_data", 64'(data_out), 64'd17);
    @(negedge clk);
    check("bubble_no_valid", 64'(out_valid), 64'd0);
    check("bubble_hold_data", 64'(data_out), 64'd17);
    tick();

    // ---- back-to-back table stream ----
    out_cyc.delete();
    for (int i = 0; i < NVEC; i++) begin
      expect_beat(tbl[i].exp_data, tbl[i].exp_ovf);
      send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].mode);
    end
    drain("stream_drain");
    check("stream_count", 64'(out_cyc.size()), 64'(NVEC));
    if (out_cyc.size() == NVEC) begin
      for (int i = 1; i < NVEC; i++)
        check($sformatf("stream_gap_%0d", i), 64'(out_cyc[i] - out_cyc[i-1]), 64'd1);
    end

    // ---- backpressure: 4-cycle stall mid-stream ----
    cnt0 = out_count;
    fork
      begin
        for (int i = 0; i < NBP; i++) begin
          expect_beat(bp[i].exp_data, bp[i].exp_ovf);
          send(bp[i].a, bp[i].b, bp[i].c, bp[i].mode);
        end
      end
      begin
        repeat (3) tick();
        out_ready = 1'b0;
        held = data_out;
        check("bp_first_result_held", 64'(held), 64'd5);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("bp_in_ready_low", 64'(in_ready),  64'd0);
          check("bp_out_valid",    64'(out_valid), 64'd1);
          check("bp_data_held",    64'(data_out),  64'(held));
        end
        tick();
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_count", 64'(out_count - cnt0), 64'(NBP));

    // ---- overflow run: 1 load + 16 accumulates ----
    model_beat(8'd255, 8'd255, 20'd0, 1'b0);
    send(8'd255, 8'd255, 20'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      model_beat(8'd255, 8'd255, 20'd0, 1'b1);
      send(8'd255, 8'd255, 20'd0, 1'b1);
    end
    drain("ovf_drain");
`ifdef MAC_PIPE_SAT_EN
    check("ovf_17th_data", 64'(last_data), 64'd1048575);
`else
    check("ovf_17th_data", 64'(last_data), 64'd56849);
`endif
    check("ovf_17th_flag", 64'(last_ovf), 64'd1);

    // ---- reset with two beats in flight ----
    send(8'd5, 8'd5, 20'd0, 1'b0);
    send(8'd6, 8'd6, 20'd0, 1'b1);
    cnt0 = out_count;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_data", 64'(data_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_output", 64'(out_count - cnt0), 64'd0);
    tick();
    expect_beat(20'd1, 1'b0);
    send(8'd1, 8'd1, 20'd0, 1'b1);
    drain("midrst_drain");
    check("midrst_acc_from_zero", 64'(last_data), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
